// File: rtl/hex_pkg.sv
// Purpose : shared glyph table and nibble->segment helper for the hex scan display.
// Latency : none (constants and a pure function).
// Backpressure: none.
// Contents: seg_t (gfedcba, lit=1), SEG_OFF (all segments dark), GLYPH_TAB, hex_glyph().
package hex_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;

  // Packed so that entry k sits at bits [7*k +: 7]; listed F down to 0.
  localparam logic [16*7-1:0] GLYPH_TAB = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic seg_t hex_glyph(input logic [3:0] nib);
    return GLYPH_TAB[int'(nib) * 7 +: 7];
  endfunction

endpackage

// File: rtl/hex_scan_display_if.sv
// Purpose : bundles the control-side inputs and board-side outputs of the hex scan display.
// Latency : n/a (wires only).
// Backpressure: none; the display always accepts loads.
// Ports   : iEN/iLOAD/iDATA/iDP/iBLANK_LZ from control logic; oHEX/oHEX_DP/oDIG/oFRAME to pins.
interface hex_scan_display_if #(
  parameter int N_DIGITS = 4
);
  logic                    iEN;
  logic                    iLOAD;
  logic [4*N_DIGITS-1:0]   iDATA;
  logic [N_DIGITS-1:0]     iDP;
  logic                    iBLANK_LZ;
  logic [6:0]              oHEX;
  logic                    oHEX_DP;
  logic [N_DIGITS-1:0]     oDIG;
  logic                    oFRAME;

  // Control logic that feeds the display.
  modport master (
    output iEN, iLOAD, iDATA, iDP, iBLANK_LZ,
    input  oHEX, oHEX_DP, oDIG, oFRAME
  );

  // The display driver itself.
  modport slave (
    input  iEN, iLOAD, iDATA, iDP, iBLANK_LZ,
    output oHEX, oHEX_DP, oDIG, oFRAME
  );
endinterface

// File: rtl/hex_seg_decode.sv
// Purpose : combinational hex nibble -> 7-segment glyph, active-high (lit = 1).
// Latency : 0 cycles.
// Backpressure: none.
// Ports   : nib_i (4-bit value), seg_o ({g,f,e,d,c,b,a}).
module hex_seg_decode
  import hex_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_o
);

  assign seg_o = hex_glyph(nib_i);

endmodule

// File: rtl/hex_scan_display.sv
// Purpose : time-multiplexed N-digit 7-segment driver with double-buffered data,
//           leading-zero blanking and per-slot dead time before each digit enable.
// Latency : iLOAD takes effect at the next frame boundary (same cycle if loaded on oFRAME);
//           segments are registered and settle at slot start, digit enable follows BLANK_CYC later.
// Backpressure: none; every iLOAD is accepted, last load in a frame wins.
// Ports   : iCLK, iRST (async active-high); bus = slave side of hex_scan_display_if.
module hex_scan_display
  import hex_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BLANK_CYC   = 2,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit DIG_ACT_LOW = 1'b1
) (
  input  logic                iCLK,
  input  logic                iRST,
  hex_scan_display_if.slave   bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BW = 5 * N_DIGITS;   // {nibbles, dps}

  localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  logic [PW-1:0]       pre_q, pre_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [BW-1:0]       pend_q, pend_d;
  logic [BW-1:0]       act_q, act_d;
  seg_t                seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [N_DIGITS-1:0] dig_q, dig_d;

  logic                wrap;
  logic                frame;
  logic [3:0]          sel_nib;
  logic                sel_dp;
  logic                sel_lz;
  logic                zero_above;
  seg_t                glyph;

  // Counters and buffers.
  always_comb begin
    wrap  = (pre_q == PRE_LAST);
    frame = wrap && (idx_q == IDX_LAST);
    pre_d = wrap ? '0 : pre_q + 1'b1;
    idx_d = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    // pend_d already carries a same-cycle load, so a load on the boundary
    // goes straight to the active buffer as well as to pending.
    pend_d = bus.iLOAD ? {bus.iDATA, bus.iDP} : pend_q;
    act_d  = frame ? pend_d : act_q;
  end

  // Select the digit that will be current next cycle, so the registered
  // segments line up with idx at slot start. Walking from the top digit
  // down lets zero_above track "this and every higher nibble is zero".
  always_comb begin
    sel_nib    = 4'h0;
    sel_dp     = 1'b0;
    sel_lz     = 1'b0;
    zero_above = 1'b1;
    dig_d      = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (act_d[N_DIGITS + 4*k +: 4] == 4'h0);
      if (idx_d == IW'(k)) begin
        sel_nib  = act_d[N_DIGITS + 4*k +: 4];
        sel_dp   = act_d[k];
        sel_lz   = zero_above && (k != 0);
        dig_d[k] = bus.iEN && (pre_d >= PRE_BLANK);
      end
    end
  end

  hex_seg_decode u_dec (
    .nib_i (sel_nib),
    .seg_o (glyph)
  );

  // Blanking only darkens the segments; the decimal point stays honoured.
  always_comb begin
    seg_d = (bus.iBLANK_LZ && sel_lz) ? SEG_OFF : glyph;
    dp_d  = sel_dp;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pre_q  <= '0;
      idx_q  <= '0;
      pend_q <= '0;
      act_q  <= '0;
      seg_q  <= SEG_OFF;
      dp_q   <= 1'b0;
      dig_q  <= '0;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      dig_q  <= dig_d;
    end
  end

  // Polarity is applied last so reset levels are always the dark/off level.
  assign bus.oHEX    = SEG_ACT_LOW ? ~seg_q : seg_q;
  assign bus.oHEX_DP = SEG_ACT_LOW ? ~dp_q  : dp_q;
  assign bus.oDIG    = DIG_ACT_LOW ? ~dig_q : dig_q;
  assign bus.oFRAME  = frame;

endmodule

// File: tb/tb_hex_scan_display.sv
// Purpose : directed self-checking bench for hex_scan_display (4 digits, SCAN_DIV=8, BLANK_CYC=2, active-low).
// Latency : n/a.
// Backpressure: n/a.
module tb_hex_scan_display;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   tcount;     // rising edges since reset release
  int   nframe;

  hex_scan_display_if #(.N_DIGITS(4)) bus ();

  hex_scan_display #(
    .N_DIGITS    (4),
    .SCAN_DIV    (8),
    .BLANK_CYC   (2),
    .SEG_ACT_LOW (1'b1),
    .DIG_ACT_LOW (1'b1)
  ) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go_to(input int target);
    while (tcount < target) begin
      @(posedge clk);
      #1;
      tcount++;
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p);
    bus.iLOAD = 1'b1;
    bus.iDATA = d;
    bus.iDP   = p;
    @(posedge clk);
    #1;
    tcount++;
    bus.iLOAD = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    tcount        = 0;
    rst           = 1'b1;
    bus.iEN       = 1'b1;
    bus.iLOAD     = 1'b0;
    bus.iDATA     = 16'h0000;
    bus.iDP       = 4'b0000;
    bus.iBLANK_LZ = 1'b0;

    // Reset levels
    #12;
    chk("rst_dig",   32'(bus.oDIG),    32'h0000000F);
    chk("rst_hex",   32'(bus.oHEX),    32'h0000007F);
    chk("rst_dp",    32'(bus.oHEX_DP), 32'h00000001);
    chk("rst_frame", 32'(bus.oFRAME),  32'h00000000);
    @(negedge clk);
    rst = 1'b0;

    // Scan walk with default (all-zero) data
    go_to(1);
    chk("blank_t1",  32'(bus.oDIG), 32'h0000000F);
    go_to(2);
    chk("dig0_on",   32'(bus.oDIG), 32'h0000000E);
    chk("zero_d0",   32'(bus.oHEX), 32'h00000040);
    go_to(8);
    chk("blank_t8",  32'(bus.oDIG), 32'h0000000F);
    go_to(10);
    chk("dig1_on",   32'(bus.oDIG), 32'h0000000D);
    go_to(31);
    chk("frame_t31", 32'(bus.oFRAME), 32'h00000001);
    chk("dig3_t31",  32'(bus.oDIG), 32'h00000007);
    go_to(32);
    chk("frame_t32", 32'(bus.oFRAME), 32'h00000000);
    chk("wrap_dig",  32'(bus.oDIG), 32'h0000000F);

    // Mid-frame load is held until the frame boundary
    go_to(34);
    load(16'h12AB, 4'b0100);
    go_to(42);
    chk("hold_hex",  32'(bus.oHEX), 32'h00000040);
    chk("hold_dp",   32'(bus.oHEX_DP), 32'h00000001);
    go_to(63);
    chk("frame_t63", 32'(bus.oFRAME), 32'h00000001);
    go_to(66);
    chk("12ab_d0",   32'(bus.oHEX), 32'h00000003);
    chk("12ab_dp0",  32'(bus.oHEX_DP), 32'h00000001);
    go_to(74);
    chk("12ab_d1",   32'(bus.oHEX), 32'h00000008);
    go_to(82);
    chk("12ab_d2",   32'(bus.oHEX), 32'h00000024);
    chk("12ab_dp2",  32'(bus.oHEX_DP), 32'h00000000);
    chk("12ab_dig2", 32'(bus.oDIG), 32'h0000000B);
    go_to(90);
    chk("12ab_d3",   32'(bus.oHEX), 32'h00000079);
    chk("12ab_dp3",  32'(bus.oHEX_DP), 32'h00000001);

    // Leading-zero blanking
    go_to(100);
    bus.iBLANK_LZ = 1'b1;
    load(16'h0050, 4'b0000);
    go_to(130);
    chk("lz50_d0",   32'(bus.oHEX), 32'h00000040);
    go_to(138);
    chk("lz50_d1",   32'(bus.oHEX), 32'h00000012);
    go_to(140);
    load(16'h0000, 4'b0010);
    go_to(146);
    chk("lz50_d2",   32'(bus.oHEX), 32'h0000007F);
    go_to(154);
    chk("lz50_d3",   32'(bus.oHEX), 32'h0000007F);
    go_to(162);
    chk("lz0_d0",    32'(bus.oHEX), 32'h00000040);
    go_to(170);
    chk("lz0_d1",    32'(bus.oHEX), 32'h0000007F);
    chk("lz0_dp1",   32'(bus.oHEX_DP), 32'h00000000);
    go_to(178);
    chk("lz0_d2",    32'(bus.oHEX), 32'h0000007F);
    chk("lz0_dp2",   32'(bus.oHEX_DP), 32'h00000001);
    go_to(186);
    chk("lz0_d3",    32'(bus.oHEX), 32'h0000007F);

    // Load on the frame cycle commits immediately
    go_to(191);
    chk("frame_t191", 32'(bus.oFRAME), 32'h00000001);
    bus.iBLANK_LZ = 1'b0;
    load(16'hFFFF, 4'b0000);
    go_to(194);
    chk("ffff_d0",   32'(bus.oHEX), 32'h0000000E);
    chk("ffff_dp0",  32'(bus.oHEX_DP), 32'h00000001);

    // Two loads in one frame: last one wins
    go_to(200);
    load(16'h1111, 4'b0000);
    go_to(210);
    load(16'h2222, 4'b0001);
    go_to(218);
    chk("ffff_d3",   32'(bus.oHEX), 32'h0000000E);
    go_to(226);
    chk("last_d0",   32'(bus.oHEX), 32'h00000024);
    chk("last_dp0",  32'(bus.oHEX_DP), 32'h00000000);
    go_to(250);
    chk("last_d3",   32'(bus.oHEX), 32'h00000024);
    chk("last_dp3",  32'(bus.oHEX_DP), 32'h00000001);

    // oFRAME pulses once per 32 cycles
    nframe = 0;
    for (int i = 0; i < 64; i++) begin
      go_to(tcount + 1);
      if (bus.oFRAME === 1'b1) nframe++;
    end
    chk("frame_cnt", 32'(nframe), 32'd2);

    // iEN low for five cycles mid-slot
    go_to(321);
    bus.iEN = 1'b0;
    go_to(322);
    chk("en0_t322",  32'(bus.oDIG), 32'h0000000F);
    go_to(326);
    chk("en0_t326",  32'(bus.oDIG), 32'h0000000F);
    bus.iEN = 1'b1;
    go_to(327);
    chk("en1_t327",  32'(bus.oDIG), 32'h0000000E);
    go_to(328);
    chk("en1_t328",  32'(bus.oDIG), 32'h0000000F);
    go_to(329);
    load(16'h9999, 4'b1111);
    go_to(332);
    chk("pre_rst_dig", 32'(bus.oDIG), 32'h0000000D);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_dig",  32'(bus.oDIG),    32'h0000000F);
    chk("arst_hex",  32'(bus.oHEX),    32'h0000007F);
    chk("arst_dp",   32'(bus.oHEX_DP), 32'h00000001);
    @(negedge clk);
    rst    = 1'b0;
    tcount = 0;
    go_to(2);
    chk("post_rst_dig", 32'(bus.oDIG), 32'h0000000E);
    go_to(34);
    chk("pend_lost_hex", 32'(bus.oHEX), 32'h00000040);
    chk("pend_lost_dp",  32'(bus.oHEX_DP), 32'h00000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
